// File: rtl/booth_inverse_divider.sv
// Sequential unsigned restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per clock behind a start/busy/done handshake.
//
// state   | meaning
// IDLE    | waiting for start; operands latched on accept
// RUN     | one restoring iteration per clock, WIDTH iterations
// DONE    | result cycle; when entered straight from IDLE (busy still high) it
//         | first resolves the divide-by-zero / overflow result, then pulses done
module booth_inverse_divider #(
   parameter int WIDTH = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               div_by_zero,
   output logic               overflow
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] shf_q, shf_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rmd_q, rmd_d;
   logic             dz_q, dz_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH:0]   step_s;
   logic [WIDTH:0]   step_t;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] shf_nx;

   // The partial remainder always stays below the divisor, so its top bit is
   // implicitly zero and only WIDTH bits are stored.
   always_comb begin
      step_s = {rem_q, shf_q[WIDTH-1]};
      step_t = step_s - {1'b0, dvs_q};
      if (!step_t[WIDTH]) begin
         rem_nx = step_t[WIDTH-1:0];
         shf_nx = {shf_q[WIDTH-2:0], 1'b1};
      end else begin
         rem_nx = step_s[WIDTH-1:0];
         shf_nx = {shf_q[WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      shf_d   = shf_q;
      dvs_d   = dvs_q;
      busy_d  = busy_q;
      done_d  = done_q;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               dvs_d  = divisor;
               rem_d  = dividend[2*WIDTH-1:WIDTH];
               shf_d  = dividend[WIDTH-1:0];
               cnt_d  = '0;
               dz_d   = 1'b0;
               ovf_d  = 1'b0;
               busy_d = 1'b1;
               if (divisor == '0 || dividend[2*WIDTH-1:WIDTH] >= divisor)
                  state_d = ST_DONE;
               else
                  state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            rem_d = rem_nx;
            shf_d = shf_nx;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               quo_d   = shf_nx;
               rmd_d   = rem_nx;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (busy_q) begin
               busy_d = 1'b0;
               done_d = 1'b1;
               quo_d  = '1;
               if (dvs_q == '0) begin
                  dz_d  = 1'b1;
                  rmd_d = shf_q;
               end else begin
                  ovf_d = 1'b1;
                  rmd_d = '0;
               end
            end else begin
               done_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         shf_q   <= '0;
         dvs_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quo_q   <= '0;
         rmd_q   <= '0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         shf_q   <= shf_d;
         dvs_q   <= dvs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quo_q   <= quo_d;
         rmd_q   <= rmd_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = rmd_q;
   assign div_by_zero = dz_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_booth_inverse_divider.sv
// Scoreboard bench for booth_inverse_divider: the driver pushes expected results
// computed with plain integer division, the monitor pops them on each done pulse.
module tb_booth_inverse_divider;

   localparam int WIDTH = 8;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic [2*WIDTH-1:0] dividend = '0;
   logic [WIDTH-1:0]   divisor = '0;
   logic               busy, done, div_by_zero, overflow;
   logic [WIDTH-1:0]   quotient, remainder;

   booth_inverse_divider #(.WIDTH(WIDTH)) dut (
      .clock(clock), .reset(reset), .start(start), .dividend(dividend),
      .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
      .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      int unsigned q;
      int unsigned r;
      int unsigned dz;
      int unsigned ov;
      int          acc;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input int unsigned dvd, input int unsigned dvs, input int acc);
      exp_t e;
      e.acc = acc;
      e.dz = 0;
      e.ov = 0;
      if (dvs == 0) begin
         e.q = 255; e.r = dvd % 256; e.dz = 1; e.lat = 1;
      end else if (dvd / dvs > 255) begin
         e.q = 255; e.r = 0; e.ov = 1; e.lat = 1;
      end else begin
         e.q = dvd / dvs; e.r = dvd % dvs; e.lat = WIDTH;
      end
      return e;
   endfunction

   // Monitor: samples 1 time unit after each rising edge.
   always begin
      @(posedge clock);
      cyc++;
      #1;
      if (!reset) begin
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("latency", cyc - e.acc, e.lat);
               chk("quotient", quotient, e.q);
               chk("remainder", remainder, e.r);
               chk("div_by_zero", div_by_zero, e.dz);
               chk("overflow", overflow, e.ov);
               chk("busy_at_done", busy, 0);
            end
         end else if (sb.size() > 0 && cyc >= sb[0].acc) begin
            chk("busy_in_flight", busy, 1);
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || done) && n < 60) begin
         @(negedge clock);
         n++;
      end
      if (busy || done) begin
         errors++;
         $display("FAIL wait_idle: busy=%0b done=%0b still high after %0d cycles", busy, done, n);
      end
   endtask

   task automatic do_op(input int unsigned dvd, input int unsigned dvs);
      wait_idle();
      start    = 1'b1;
      dividend = dvd[2*WIDTH-1:0];
      divisor  = dvs[WIDTH-1:0];
      sb.push_back(model(dvd, dvs, cyc + 1));
      @(negedge clock);
      start    = 1'b0;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d results never arrived", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      int unsigned dvd, dvs;
      int c0;
      repeat (3) @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_flags", {div_by_zero, overflow}, 0);
      reset = 1'b0;
      @(negedge clock);

      do_op(2500, 50);
      do_op(2549, 50);
      do_op(16'hFEFF, 255);
      do_op(1234, 0);
      drain();
      do_op(16'h3200, 50);
      drain();
      repeat (2) @(negedge clock);
      chk("ovf_hold", overflow, 1);
      do_op(2500, 50);
      chk("ovf_clear_at_accept", overflow, 0);
      drain();

      // start pulse while busy must be ignored
      do_op(2500, 50);
      repeat (2) @(negedge clock);
      start = 1'b1; dividend = 16'd100; divisor = 8'd10;
      @(negedge clock);
      start = 1'b0;
      drain();

      // reset mid-operation
      do_op(2549, 50);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      sb.delete();
      @(negedge clock);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_quotient", quotient, 0);
      chk("midrst_remainder", remainder, 0);
      chk("midrst_flags", {div_by_zero, overflow}, 0);
      reset = 1'b0;
      @(negedge clock);
      do_op(100, 7);
      drain();

      // back-to-back: start held high gives one accept every WIDTH+2 cycles
      wait_idle();
      c0 = cyc;
      start = 1'b1; dividend = 16'd2500; divisor = 8'd50;
      for (int i = 0; i < 3; i++) sb.push_back(model(2500, 50, c0 + 1 + i * (WIDTH + 2)));
      while (cyc < c0 + 3 * (WIDTH + 2)) @(negedge clock);
      start = 1'b0;
      drain();

      for (int i = 0; i < 40; i++) begin
         dvs = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 255);
         if (dvs != 0 && $urandom_range(0, 3) != 0)
            dvd = $urandom_range(0, dvs * 256 - 1);
         else
            dvd = $urandom_range(0, 65535);
         do_op(dvd, dvs);
      end
      drain();

      repeat (3) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
